// File: rtl/nn_pkg.sv
// Shared fixed-point types and the layer sequencer state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package nn_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int FIXED_WIDTH    = INTEGER_WIDTH + FRACTION_WIDTH;

  // Signed Q(INTEGER_WIDTH).(FRACTION_WIDTH) value; 1.0 == 1 << FRACTION_WIDTH.
  typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } sequencer_state_t;

endpackage

// File: rtl/watchdog_counter.sv
// Counts enabled cycles and flags when TIMEOUT_CYCLES have elapsed.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; clear has priority over counting.
module watchdog_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles, saturating once the limit is reached.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = enable && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Time-multiplexes NUM_NEURONS evaluations onto one shared neuron and collects results.
// Latency: inputs_ready to output_ready spans 1 + NUM_NEURONS*(2 + neuron latency) + 1 cycles.
// Backpressure: one request may queue while busy; further requests are dropped.
// Optional watchdog: define LAYER_SEQUENCER_TIMEOUT_EN.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               inputs_ready,
  output logic                               neuron_start,
  output logic [$clog2(NUM_NEURONS)-1:0]     neuron_index,
  input  logic                               neuron_output_ready,
  input  fixed_t                             neuron_out,
  output fixed_t [NUM_NEURONS-1:0]           outputs,
  output logic                               output_ready,
  output logic                               busy,
  output logic                               error
);

  localparam int                IDX_W = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_NEURONS - 1);

  if (NUM_NEURONS < 2 || NUM_NEURONS > 256) begin : g_bad_num_neurons
    $error("NUM_NEURONS must lie in 2..256");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  sequencer_state_t         r_state;
  sequencer_state_t         w_next;
  logic [IDX_W-1:0]         r_index;
  logic                     r_pending;
  fixed_t [NUM_NEURONS-1:0] r_outputs;
  logic                     w_store;
  logic                     w_timeout;
  fixed_t                   w_store_dat;

`ifdef LAYER_SEQUENCER_TIMEOUT_EN
  logic w_expired;
  logic r_zero;
  logic r_error;

  watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (r_state != S_WAIT),
    .enable (r_state == S_WAIT),
    .expired(w_expired)
  );

  // A real reply in the expiring cycle wins over the timeout.
  assign w_timeout = (r_state == S_WAIT) && w_expired && !neuron_output_ready;

  // Remember a timeout for the following STORE and latch the sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_zero  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_zero  <= w_timeout;
      r_error <= r_error | w_timeout;
    end
  end

  assign w_store_dat = r_zero ? fixed_t'(0) : neuron_out;
  assign error       = r_error;
`else
  assign w_timeout   = 1'b0;
  assign w_store_dat = neuron_out;
  assign error       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs; neuron_output_ready only matters in WAIT.
  always_comb begin
    w_next       = r_state;
    neuron_start = 1'b0;
    output_ready = 1'b0;
    busy         = 1'b1;
    w_store      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (inputs_ready || r_pending) w_next = S_START;
      end
      S_START: begin
        neuron_start = 1'b1;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        if (neuron_output_ready || w_timeout) w_next = S_STORE;
      end
      S_STORE: begin
        w_store = 1'b1;
        w_next  = (r_index < LAST) ? S_START : S_DONE;
      end
      S_DONE: begin
        output_ready = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Neuron index: cleared when a pass launches, advanced after each store, never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_index <= '0;
    end else if (r_state == S_IDLE && w_next == S_START) begin
      r_index <= '0;
    end else if (w_store && r_index != LAST) begin
      r_index <= r_index + 1'b1;
    end
  end

  // One-deep request queue: consumed in IDLE, set by a request arriving while busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_pending <= 1'b0;
    end else if (inputs_ready) begin
      r_pending <= 1'b1;
    end
  end

  // Result bank: written only in STORE so the previous pass stays readable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_outputs <= '0;
    end else if (w_store) begin
      r_outputs[r_index] <= w_store_dat;
    end
  end

  assign neuron_index = r_index;
  assign outputs      = r_outputs;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a behavioural shared-neuron model.
// Latency: model replies lat cycles after neuron_start with out=(index+1)*scale.
// Backpressure: exercises request queueing, dropping and DONE-coincident requests.
module tb_layer_sequencer;
  import nn_pkg::*;

  localparam int N = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   inputs_ready;
  logic                   neuron_start;
  logic [$clog2(N)-1:0]   neuron_index;
  logic                   neuron_output_ready;
  fixed_t                 neuron_out;
  fixed_t [N-1:0]         outputs;
  logic                   output_ready;
  logic                   busy;
  logic                   error;

  int total = 0;
  int bad   = 0;

  // Model controls, written by the main sequence and read by the neuron model.
  int lat           = 5;
  int scale         = 256;
  int mute_idx      = -1;
  int force_cnt     = 0;
  bit spur_on_start = 1'b0;
  // Written only by the neuron model.
  int starts        = 0;

  always #5 clock = ~clock;

  layer_sequencer #(
    .NUM_NEURONS   (N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .inputs_ready       (inputs_ready),
    .neuron_start       (neuron_start),
    .neuron_index       (neuron_index),
    .neuron_output_ready(neuron_output_ready),
    .neuron_out         (neuron_out),
    .outputs            (outputs),
    .output_ready       (output_ready),
    .busy               (busy),
    .error              (error)
  );

  // Shared neuron model: reply pulse lat cycles after the START cycle.
  initial begin : neuron_model
    int cnt;
    int cur;
    int seen;
    cnt = 0;
    cur = 0;
    seen = 0;
    neuron_output_ready = 1'b0;
    neuron_out = '0;
    forever begin
      @(posedge clock);
      #1;
      neuron_output_ready = 1'b0;
      if (seen != force_cnt) begin
        seen = force_cnt;
        neuron_output_ready = 1'b1;
        neuron_out = 16'sh7F00;
      end else if (neuron_start) begin
        cnt = lat;
        cur = int'(neuron_index);
        starts++;
        if (spur_on_start) begin
          neuron_output_ready = 1'b1;
          neuron_out = 16'sh7F00;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && cur != mute_idx) begin
          neuron_output_ready = 1'b1;
          neuron_out = fixed_t'((cur + 1) * scale);
        end
      end
    end
  end

  initial begin : global_limit
    #400000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, ".out0"}, int'($signed(outputs[0])), e0);
    check({tag, ".out1"}, int'($signed(outputs[1])), e1);
    check({tag, ".out2"}, int'($signed(outputs[2])), e2);
    check({tag, ".out3"}, int'($signed(outputs[3])), e3);
  endtask

  // Wait (bounded) for the output_ready pulse.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!output_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
    check({tag, ".done_seen"}, int'(output_ready), 1);
  endtask

  // Wait (bounded) for the START cycle of neuron idx.
  task automatic wait_start(input string tag, input int idx);
    int k;
    k = 0;
    while (!(neuron_start && int'(neuron_index) == idx) && k < 200) begin
      @(negedge clock);
      k++;
    end
    check({tag, ".start_seen"}, int'(neuron_start), 1);
  endtask

  task automatic pulse_inputs();
    @(negedge clock);
    inputs_ready = 1'b1;
    @(negedge clock);
    inputs_ready = 1'b0;
  endtask

  // One full pass; cyc counts cycles inclusively from the inputs_ready cycle to the output_ready cycle.
  task automatic run_pass(input int lat_i, input int scale_i, output int cyc);
    lat   = lat_i;
    scale = scale_i;
    @(negedge clock);
    inputs_ready = 1'b1;
    cyc = 1;
    do begin
      @(negedge clock);
      inputs_ready = 1'b0;
      cyc++;
    end while (!output_ready && cyc < 300);
  endtask

  typedef struct {
    int lat;
    int scale;
    int exp_cyc;
    int e0;
    int e1;
    int e2;
    int e3;
  } vec_t;

  initial begin : main
    vec_t vecs[4];
    int   cyc;
    int   s0;
    int   pulses;

    vecs[0] = '{5,  256, 30,  256,  512,  768,  1024};
    vecs[1] = '{1, -128, 14, -128, -256, -384,  -512};
    vecs[2] = '{3,  576, 22,  576, 1152, 1728,  2304};
    vecs[3] = '{2, 8191, 18, 8191, 16382, 24573, 32764};

    reset        = 1'b0;
    inputs_ready = 1'b0;
    #12;
    check("reset.busy", int'(busy), 0);
    check("reset.start", int'(neuron_start), 0);
    check("reset.ready", int'(output_ready), 0);
    check("reset.error", int'(error), 0);
    check("reset.index", int'(neuron_index), 0);
    check_outs("reset", 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Table of passes with different neuron latencies and result values.
    for (int i = 0; i < 4; i++) begin
      s0 = starts;
      run_pass(vecs[i].lat, vecs[i].scale, cyc);
      check($sformatf("vec%0d.cycles", i), cyc, vecs[i].exp_cyc);
      check_outs($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
      @(negedge clock);
      check($sformatf("vec%0d.ready_one_cycle", i), int'(output_ready), 0);
      check($sformatf("vec%0d.idle", i), int'(busy), 0);
      check($sformatf("vec%0d.starts", i), starts - s0, 4);
    end

    // Spurious reply while IDLE: nothing stored, index stays at the last neuron.
    @(negedge clock);
    force_cnt++;
    repeat (3) @(negedge clock);
    check("spur_idle.index", int'(neuron_index), 3);
    check("spur_idle.busy", int'(busy), 0);
    check_outs("spur_idle", 8191, 16382, 24573, 32764);

    // Spurious reply during START: ignored, previous results still readable.
    spur_on_start = 1'b1;
    lat   = 5;
    scale = 256;
    @(negedge clock);
    inputs_ready = 1'b1;
    @(negedge clock);
    inputs_ready = 1'b0;
    check("spur_start.start", int'(neuron_start), 1);
    @(negedge clock);
    check("spur_start.index", int'(neuron_index), 0);
    check("spur_start.busy", int'(busy), 1);
    check("spur_start.out0_kept", int'($signed(outputs[0])), 8191);
    wait_done("spur_start");
    spur_on_start = 1'b0;
    check_outs("spur_start", 256, 512, 768, 1024);
    repeat (3) @(negedge clock);

    // Two extra requests in one pass: exactly one queued pass runs, the other is dropped.
    s0 = starts;
    pulse_inputs();
    pulses = 0;
    for (int c = 0; c < 120; c++) begin
      inputs_ready = (c == 10 || c == 15);
      if (output_ready) pulses++;
      @(negedge clock);
    end
    inputs_ready = 1'b0;
    check("queue.passes", pulses, 2);
    check("queue.starts", starts - s0, 8);
    check("queue.idle", int'(busy), 0);

    // Request coincident with DONE: IDLE for one cycle, then START.
    pulse_inputs();
    wait_done("coincide.first");
    inputs_ready = 1'b1;
    @(negedge clock);
    inputs_ready = 1'b0;
    check("coincide.idle_start", int'(neuron_start), 0);
    check("coincide.idle_busy", int'(busy), 0);
    @(negedge clock);
    check("coincide.start", int'(neuron_start), 1);
    check("coincide.index", int'(neuron_index), 0);
    @(negedge clock);
    wait_done("coincide.second");
    check_outs("coincide", 256, 512, 768, 1024);
    repeat (3) @(negedge clock);

    // Reset during WAIT of neuron 2 clears everything immediately.
    pulse_inputs();
    wait_start("midreset", 2);
    @(negedge clock);
    check("midreset.wait_busy", int'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("midreset.busy", int'(busy), 0);
    check("midreset.index", int'(neuron_index), 0);
    check("midreset.start", int'(neuron_start), 0);
    check("midreset.ready", int'(output_ready), 0);
    check_outs("midreset", 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    run_pass(3, 576, cyc);
    check("after_reset.cycles", cyc, 22);
    check_outs("after_reset", 576, 1152, 1728, 2304);
    repeat (3) @(negedge clock);

`ifdef LAYER_SEQUENCER_TIMEOUT_EN
    // Neuron 1 never replies: watchdog stores 0 and the pass completes with error set.
    mute_idx = 1;
    lat   = 5;
    scale = 256;
    pulse_inputs();
    wait_start("wd", 1);
    repeat (8) @(negedge clock);
    check("wd.error_before", int'(error), 0);
    check("wd.index", int'(neuron_index), 1);
    @(negedge clock);
    check("wd.error_set", int'(error), 1);
    wait_done("wd");
    check_outs("wd", 256, 0, 768, 1024);
    mute_idx = -1;
    repeat (2) @(negedge clock);
    run_pass(5, 256, cyc);
    check("wd.next_cycles", cyc, 30);
    check("wd.error_sticky", int'(error), 1);
    check("wd.next_out1", int'($signed(outputs[1])), 512);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("wd.error_cleared", int'(error), 0);
    @(negedge clock);
    reset = 1'b1;
`else
    // Without the watchdog a silent neuron stalls the pass indefinitely.
    mute_idx = 1;
    lat   = 5;
    scale = 256;
    pulse_inputs();
    wait_start("stall", 1);
    repeat (100) @(negedge clock);
    check("stall.busy", int'(busy), 1);
    check("stall.index", int'(neuron_index), 1);
    check("stall.error", int'(error), 0);
    check("stall.out1_kept", int'($signed(outputs[1])), 1152);
    check("stall.out0_new", int'($signed(outputs[0])), 256);
    reset = 1'b0;
    #1;
    check("stall.reset_busy", int'(busy), 0);
    mute_idx = -1;
    @(negedge clock);
    reset = 1'b1;
`endif
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: neurons in the layer, time-multiplexed onto one shared neuron datapath; legal range 2..256.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit, used only when LAYER_SEQUENCER_TIMEOUT_EN is defined.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port inputs_ready, input, 1: one-cycle pulse from the previous layer meaning its outputs are valid.
REQ-006 SHALL have port neuron_start, output, 1: one-cycle pulse to the shared neuron's inputs_ready.
REQ-007 SHALL have port neuron_index, output, $clog2(NUM_NEURONS): selects the weight/bias bank of the neuron currently being evaluated.
REQ-008 SHALL have port neuron_output_ready, input, 1: done pulse from the shared neuron.
REQ-009 SHALL have port neuron_out, input, signed fixed_t: result from the shared neuron.
REQ-010 SHALL have port outputs, output, fixed_t[NUM_NEURONS]: layer result register bank.
REQ-011 SHALL have port output_ready, output, 1: one-cycle pulse when every entry of outputs is updated.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port error, output, 1: sticky watchdog flag; tied 0 when the watchdog is compiled out.

Function
REQ-014 SHALL implement the FSM IDLE -> START -> WAIT -> STORE -> (START if index < NUM_NEURONS-1, else DONE) -> IDLE.
REQ-015 SHALL leave IDLE on inputs_ready=1 or pending=1, clear neuron_index to 0, and clear pending.
REQ-016 SHALL assert neuron_start for exactly one cycle, in START only.
REQ-017 SHALL hold neuron_index stable from START through STORE of the same neuron.
REQ-018 SHALL stay in WAIT until neuron_output_ready=1, then go to STORE on the next edge.
REQ-019 SHALL, in STORE, write neuron_out into outputs[neuron_index], then increment neuron_index; it SHALL NOT wrap within a pass.
REQ-020 SHALL leave outputs unchanged outside STORE, so the previous pass's results stay readable while a pass runs.
REQ-021 SHALL assert output_ready for exactly one cycle, in DONE; latency from inputs_ready to output_ready = 1 + NUM_NEURONS*(2 + neuron latency) + 1 cycles.
REQ-022 SHALL set a one-deep pending flag on inputs_ready while busy; a second pulse while pending is set SHALL be dropped.
REQ-023 SHALL, on inputs_ready in the same cycle as DONE, set pending, so the next pass starts from IDLE one cycle later.
REQ-024 SHALL ignore neuron_output_ready in any state other than WAIT.

Reset
REQ-025 SHALL, on reset low at any time including mid-pass, immediately force: state IDLE, neuron_index 0, pending 0, neuron_start 0, output_ready 0, busy 0, error 0, all outputs 0.
REQ-026 SHALL resume normal operation on the first rising clock edge after reset is released.

Configuration
REQ-027 SHALL, with LAYER_SEQUENCER_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT_CYCLES it SHALL set error, store 0 to outputs[neuron_index], and continue as in STORE.
REQ-028 SHALL keep error set until reset once it is set.
REQ-029 SHALL, without LAYER_SEQUENCER_TIMEOUT_EN, contain no watchdog counter and SHALL wait in WAIT indefinitely.

Structure
REQ-030 SHALL take INTEGER_WIDTH, FRACTION_WIDTH, the fixed_t typedef and the sequencer_state_t enum from the shared package nn_pkg.
REQ-031 SHALL place the watchdog in one sub-module, watchdog_counter (inputs clear and enable; output expired), instantiated only under LAYER_SEQUENCER_TIMEOUT_EN.

Verification
REQ-032 SHALL cover: NUM_NEURONS=4, neuron model replies 5 cycles after start with out=index+1.0 -> outputs={1.0,2.0,3.0,4.0}, output_ready exactly 30 cycles after inputs_ready.
REQ-033 SHALL cover: second inputs_ready mid-pass -> exactly one extra pass runs back-to-back; a third pulse in the same pass is dropped.
REQ-034 SHALL cover: reset low during WAIT of neuron 2 -> all outputs 0 and state IDLE immediately; a fresh pass then completes normally.
REQ-035 SHALL cover: spurious neuron_output_ready in IDLE or START -> no store, and neuron_index unchanged.
REQ-036 SHALL cover: macro defined, TIMEOUT_CYCLES=8, neuron 1 never replies -> error=1 after 8 WAIT cycles, outputs[1]=0, the pass completes, and error persists until reset.
REQ-037 SHALL cover: inputs_ready coincident with DONE -> output_ready pulse seen, then the next neuron_start occurs 2 cycles later.
